// File: rtl/sign_ext_pkg.sv
// sign_ext_pkg
//   Shared definitions for the RV32I immediate extender. The decoder and
//   control logic use the imm_type_e codes from here to select how the
//   immediate is assembled from an instruction word.
//   No ports (package).
package sign_ext_pkg;

    localparam int unsigned XLEN = 32;

    // Immediate format select. 3'b111 is reserved and decodes like IMM_NONE.
    typedef enum logic [2:0] {
        IMM_NONE  = 3'b000,
        IMM_I     = 3'b001,
        IMM_S     = 3'b010,
        IMM_B     = 3'b011,
        IMM_U     = 3'b100,
        IMM_J     = 3'b101,
        IMM_SHAMT = 3'b110,
        IMM_RSVD  = 3'b111
    } imm_type_e;

endpackage : sign_ext_pkg

// File: rtl/sign_ext_if.sv
// sign_ext_if
//   Request/result bundle for the immediate extender.
//   Handshake: valid-only, no ready. The master asserts in_valid for
//   exactly the cycles whose instruct/imm_type must be decoded; every such
//   cycle is accepted at the next rising edge. out_valid is high for one
//   cycle per accepted request, one edge later. There is no back-pressure.
//   Signals:
//     imm_type  [2:0]  format select (sign_ext_pkg::imm_type_e codes)
//     instruct  [31:0] raw instruction word
//     in_valid         request qualifier
//     imm_out   [31:0] registered extended immediate
//     out_valid        imm_out holds a result from the previous edge
//   Modports: master (requester), slave (sign_ext).
interface sign_ext_if;
    import sign_ext_pkg::*;

    logic [2:0]      imm_type;
    logic [XLEN-1:0] instruct;
    logic            in_valid;
    logic [XLEN-1:0] imm_out;
    logic            out_valid;

    modport master (
        output imm_type,
        output instruct,
        output in_valid,
        input  imm_out,
        input  out_valid
    );

    modport slave (
        input  imm_type,
        input  instruct,
        input  in_valid,
        output imm_out,
        output out_valid
    );

endinterface : sign_ext_if

// File: rtl/sign_ext_imm_decode.sv
// imm_decode
//   Purely combinational RV32I immediate assembly.
//   Ports:
//     instruct [31:0] in   raw instruction word
//     imm_type [2:0]  in   format select (imm_type_e codes)
//     imm      [31:0] out  extended immediate
//   Every sign-extended format takes its sign from instruct[31]. NONE,
//   reserved and any unknown select fall into the default branch and
//   produce zero.
module imm_decode
    import sign_ext_pkg::*;
(
    input  logic [XLEN-1:0] instruct,
    input  logic [2:0]      imm_type,
    output logic [XLEN-1:0] imm
);

    logic sgn;
    assign sgn = instruct[31];

    // The opcode field never contributes to an immediate.
    logic unused_opcode;
    assign unused_opcode = ^instruct[6:0];

    always_comb begin
        imm = '0;
        case (imm_type)
            IMM_I:     imm = {{20{sgn}}, instruct[31:20]};
            IMM_S:     imm = {{20{sgn}}, instruct[31:25], instruct[11:7]};
            IMM_B:     imm = {{19{sgn}}, instruct[31], instruct[7],
                              instruct[30:25], instruct[11:8], 1'b0};
            IMM_U:     imm = {instruct[31:12], 12'h000};
            IMM_J:     imm = {{11{sgn}}, instruct[31], instruct[19:12],
                              instruct[20], instruct[30:21], 1'b0};
            IMM_SHAMT: imm = {27'd0, instruct[24:20]};
            default:   imm = '0;
        endcase
    end

endmodule : imm_decode

// File: rtl/sign_ext.sv
// sign_ext
//   Registered RV32I immediate extender with one clock of latency.
//   Ports:
//     clk    in  rising-edge clock
//     rst_n  in  asynchronous active-low reset (clears imm_out/out_valid)
//     bus    sign_ext_if.slave  request (imm_type, instruct, in_valid) and
//            result (imm_out, out_valid)
//   On an edge with in_valid=1 the decoded immediate is captured and
//   out_valid rises; with in_valid=0 imm_out keeps its last value and
//   out_valid drops.
module sign_ext
    import sign_ext_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    sign_ext_if.slave  bus
);

    logic [XLEN-1:0] imm_next;
    logic [XLEN-1:0] imm_q;
    logic            valid_q;

    imm_decode u_imm_decode (
        .instruct (bus.instruct),
        .imm_type (bus.imm_type),
        .imm      (imm_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imm_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                imm_q <= imm_next;
            end
        end
    end

    assign bus.imm_out   = imm_q;
    assign bus.out_valid = valid_q;

endmodule : sign_ext

// File: tb/tb_sign_ext.sv
// tb_sign_ext
//   Directed-vector bench for sign_ext. Expected immediates are
//   hand-computed from the RV32I immediate layouts.
module tb_sign_ext;
    import sign_ext_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    sign_ext_if bus ();

    sign_ext dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_bad = 0;
    logic [31:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Present one valid request, then check the result just after the
    // capturing edge.
    task automatic drive_vec(input string tag, input logic [2:0] t,
                             input logic [31:0] instr, input logic [31:0] exp);
        logic [31:0] e;
        @(negedge clk);
        bus.imm_type = t;
        bus.instruct = instr;
        bus.in_valid = 1'b1;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_eq({tag, "_imm"}, bus.imm_out, e);
        check_eq({tag, "_vld"}, {31'd0, bus.out_valid}, 32'd1);
    endtask

    task automatic drive_idle(input logic [31:0] instr);
        @(negedge clk);
        bus.imm_type = IMM_I;
        bus.instruct = instr;
        bus.in_valid = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n        = 1'b0;
        bus.imm_type = IMM_NONE;
        bus.instruct = 32'h0;
        bus.in_valid = 1'b0;
        #1;
        check_eq("rst_imm", bus.imm_out, 32'h0);
        check_eq("rst_vld", {31'd0, bus.out_valid}, 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("post_rst_vld", {31'd0, bus.out_valid}, 32'd0);

        // all-ones positive word
        drive_vec("p_i",     IMM_I,     32'h7FFF_FFFF, 32'h0000_07FF);
        drive_vec("p_s",     IMM_S,     32'h7FFF_FFFF, 32'h0000_07FF);
        drive_vec("p_b",     IMM_B,     32'h7FFF_FFFF, 32'h0000_0FFE);
        drive_vec("p_u",     IMM_U,     32'h7FFF_FFFF, 32'h7FFF_F000);
        drive_vec("p_j",     IMM_J,     32'h7FFF_FFFF, 32'h000F_FFFE);
        drive_vec("p_sh",    IMM_SHAMT, 32'h7FFF_FFFF, 32'h0000_001F);
        // sign bit only
        drive_vec("n_i",     IMM_I,     32'h8000_0000, 32'hFFFF_F800);
        drive_vec("n_s",     IMM_S,     32'h8000_0000, 32'hFFFF_F800);
        drive_vec("n_b",     IMM_B,     32'h8000_0000, 32'hFFFF_F000);
        drive_vec("n_u",     IMM_U,     32'h8000_0000, 32'h8000_0000);
        drive_vec("n_j",     IMM_J,     32'h8000_0000, 32'hFFF0_0000);
        drive_vec("n_sh",    IMM_SHAMT, 32'h8000_0000, 32'h0000_0000);
        // none / reserved zero the output even for an all-ones word
        drive_vec("none",    IMM_NONE,  32'hFFFF_FFFF, 32'h0000_0000);
        drive_vec("rsvd",    IMM_RSVD,  32'hFFFF_FFFF, 32'h0000_0000);
        // real encodings
        drive_vec("addi",    IMM_I,     32'hFFF0_0093, 32'hFFFF_FFFF);
        drive_vec("beq",     IMM_B,     32'hFE00_0EE3, 32'hFFFF_FFFC);
        drive_vec("jal",     IMM_J,     32'h0010_00EF, 32'h0000_0800);
        // sw x5,20(x2): imm=20 split over [31:25]/[11:7]
        drive_vec("sw",      IMM_S,     32'h0051_2A23, 32'h0000_0014);
        // slli x1,x1,13
        drive_vec("slli",    IMM_SHAMT, 32'h00D0_9093, 32'h0000_000D);

        // in_valid 1,0,1: result holds, valid drops
        drive_vec("tg_a",    IMM_U,     32'h1234_5678, 32'h1234_5000);
        drive_idle(32'hFFFF_FFFF);
        @(posedge clk);
        #1;
        check_eq("tg_hold_imm", bus.imm_out, 32'h1234_5000);
        check_eq("tg_hold_vld", {31'd0, bus.out_valid}, 32'd0);
        drive_vec("tg_b",    IMM_I,     32'h0010_0093, 32'h0000_0001);

        // asynchronous reset between edges while out_valid=1
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_imm", bus.imm_out, 32'h0);
        check_eq("arst_vld", {31'd0, bus.out_valid}, 32'd0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rel_imm", bus.imm_out, 32'h0);
        check_eq("rel_vld", {31'd0, bus.out_valid}, 32'd0);
        // first capture after release
        drive_vec("first",   IMM_J,     32'h7FFF_FFFF, 32'h000F_FFFE);
        drive_idle(32'h0);
        @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // Hard time bound so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule : tb_sign_ext
